// File: rtl/cache_tag_valid_array.sv
`default_nettype none
// ============================================================================
//  Module      : cache_tag_valid_array
//  Description : N-way set-associative tag/valid store. Registers a hit/miss
//                result and victim way one cycle after a lookup, installs
//                fills, invalidates single lines and clears the whole array
//                with a one-set-per-cycle flush sweep.
//  Ports       : clk, reset (async, active-high)
//                lookup_valid/lookup_addr/lookup_ready -> request side
//                resp_valid/hit/hit_way/victim_way     -> registered result
//                fill_valid/fill_addr                  -> line install
//                inv_valid/inv_addr                    -> line invalidate
//                flush_req/flush_busy/flush_done       -> full-array sweep
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_tag_valid_array #(
   parameter int ADDR_BITS  = 5,
   parameter int INDEX_BITS = 3,
   parameter int WAYS       = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lookup_valid,
   input  logic [ADDR_BITS-1:0]       lookup_addr,
   output logic                       lookup_ready,
   output logic                       resp_valid,
   output logic                       hit,
   output logic [$clog2(WAYS)-1:0]    hit_way,
   output logic [$clog2(WAYS)-1:0]    victim_way,
   input  logic                       fill_valid,
   input  logic [ADDR_BITS-1:0]       fill_addr,
   input  logic                       inv_valid,
   input  logic [ADDR_BITS-1:0]       inv_addr,
   input  logic                       flush_req,
   output logic                       flush_busy,
   output logic                       flush_done
);

   localparam int c_SETS     = 2**INDEX_BITS;
   localparam int c_WAY_BITS = $clog2(WAYS);
   localparam int c_TAG_BITS = ADDR_BITS - INDEX_BITS;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SWEEP = 2'd1;
   localparam logic [1:0] c_ST_DONE  = 2'd2;

   localparam logic [INDEX_BITS-1:0] c_LAST_SET = INDEX_BITS'(c_SETS - 1);

   // Array state
   logic [WAYS-1:0]       r_valid [c_SETS];
   logic [c_TAG_BITS-1:0] r_tag   [c_SETS][WAYS];
   logic [c_WAY_BITS-1:0] r_rr    [c_SETS];

   // Flush control
   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [INDEX_BITS-1:0] r_cnt;

   // Request qualification: a flush request taken in IDLE drops any
   // same-cycle lookup or fill.
   logic w_flush_start;
   logic w_lk_do;
   logic w_fill_do;
   logic w_inv_do;

   assign w_flush_start = (r_state == c_ST_IDLE) && flush_req;
   assign w_lk_do       = lookup_valid && lookup_ready && !w_flush_start;
   assign w_fill_do     = fill_valid && !flush_busy && !w_flush_start;
   assign w_inv_do      = inv_valid && !flush_busy;

   // ------------------------------------------------------------------
   // Lookup decode (reads pre-update state)
   // ------------------------------------------------------------------
   logic [INDEX_BITS-1:0] w_lk_set;
   logic [c_TAG_BITS-1:0] w_lk_tag;
   logic [WAYS-1:0]       w_lk_match;
   logic                  w_lk_hit;
   logic [c_WAY_BITS-1:0] w_lk_hit_way;
   logic [c_WAY_BITS-1:0] w_lk_free_way;
   logic [c_WAY_BITS-1:0] w_lk_victim;

   assign w_lk_set = lookup_addr[INDEX_BITS-1:0];
   assign w_lk_tag = lookup_addr[ADDR_BITS-1:INDEX_BITS];

   always_comb begin
      w_lk_match    = '0;
      w_lk_hit_way  = '0;
      w_lk_free_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_lk_match[w] = r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_tag);
      end
      // Descending scan leaves the lowest-numbered qualifying way
      for (int w = WAYS-1; w >= 0; w--) begin
         if (w_lk_match[w])           w_lk_hit_way  = c_WAY_BITS'(w);
         if (!r_valid[w_lk_set][w])   w_lk_free_way = c_WAY_BITS'(w);
      end
      w_lk_hit = |w_lk_match;
      // On a hit a fill would rewrite the matching way
      if (w_lk_hit)
         w_lk_victim = w_lk_hit_way;
      else if (&r_valid[w_lk_set])
         w_lk_victim = r_rr[w_lk_set];
      else
         w_lk_victim = w_lk_free_way;
   end

   // ------------------------------------------------------------------
   // Invalidate decode
   // ------------------------------------------------------------------
   logic [INDEX_BITS-1:0] w_inv_set;
   logic [c_TAG_BITS-1:0] w_inv_tag;
   logic [WAYS-1:0]       w_inv_match;
   logic [c_WAY_BITS-1:0] w_inv_way;
   logic                  w_inv_hit;

   assign w_inv_set = inv_addr[INDEX_BITS-1:0];
   assign w_inv_tag = inv_addr[ADDR_BITS-1:INDEX_BITS];

   always_comb begin
      w_inv_match = '0;
      w_inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_inv_match[w] = r_valid[w_inv_set][w] && (r_tag[w_inv_set][w] == w_inv_tag);
      end
      for (int w = WAYS-1; w >= 0; w--) begin
         if (w_inv_match[w]) w_inv_way = c_WAY_BITS'(w);
      end
      w_inv_hit = |w_inv_match;
   end

   // ------------------------------------------------------------------
   // Fill decode: sees the set as it looks after a same-cycle invalidate,
   // so an invalidate+fill of one line leaves it valid.
   // ------------------------------------------------------------------
   logic [INDEX_BITS-1:0] w_fill_set;
   logic [c_TAG_BITS-1:0] w_fill_tag;
   logic [WAYS-1:0]       w_fill_vpost;
   logic [WAYS-1:0]       w_fill_match;
   logic                  w_fill_hit;
   logic [c_WAY_BITS-1:0] w_fill_hit_way;
   logic [c_WAY_BITS-1:0] w_fill_free_way;
   logic [c_WAY_BITS-1:0] w_fill_way;
   logic                  w_fill_adv;

   assign w_fill_set = fill_addr[INDEX_BITS-1:0];
   assign w_fill_tag = fill_addr[ADDR_BITS-1:INDEX_BITS];

   always_comb begin
      w_fill_vpost    = r_valid[w_fill_set];
      w_fill_match    = '0;
      w_fill_hit_way  = '0;
      w_fill_free_way = '0;
      if (w_inv_do && (w_inv_set == w_fill_set))
         w_fill_vpost = w_fill_vpost & ~w_inv_match;
      for (int w = 0; w < WAYS; w++) begin
         w_fill_match[w] = w_fill_vpost[w] && (r_tag[w_fill_set][w] == w_fill_tag);
      end
      for (int w = WAYS-1; w >= 0; w--) begin
         if (w_fill_match[w])  w_fill_hit_way  = c_WAY_BITS'(w);
         if (!w_fill_vpost[w]) w_fill_free_way = c_WAY_BITS'(w);
      end
      w_fill_hit = |w_fill_match;
      if (w_fill_hit)
         w_fill_way = w_fill_hit_way;
      else if (&w_fill_vpost)
         w_fill_way = r_rr[w_fill_set];
      else
         w_fill_way = w_fill_free_way;
      // Pointer moves only when a valid line is evicted
      w_fill_adv = !w_fill_hit && (&w_fill_vpost);
   end

   // ------------------------------------------------------------------
   // Valid bits and round-robin pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < c_SETS; s++) begin
            r_valid[s] <= '0;
            r_rr[s]    <= '0;
         end
      end else if (r_state == c_ST_SWEEP) begin
         r_valid[r_cnt] <= '0;
         r_rr[r_cnt]    <= '0;
      end else begin
         if (w_inv_do && w_inv_hit)
            r_valid[w_inv_set][w_inv_way] <= 1'b0;
         // Issued after the invalidate so the fill wins on the same bit
         if (w_fill_do) begin
            r_valid[w_fill_set][w_fill_way] <= 1'b1;
            if (w_fill_adv)
               r_rr[w_fill_set] <= r_rr[w_fill_set] + c_WAY_BITS'(1);
         end
      end
   end

   // Tag storage carries no reset; valid bits qualify it
   always_ff @(posedge clk) begin
      if (w_fill_do)
         r_tag[w_fill_set][w_fill_way] <= w_fill_tag;
   end

   // ------------------------------------------------------------------
   // Registered lookup response
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         hit        <= 1'b0;
         hit_way    <= '0;
         victim_way <= '0;
      end else if (w_lk_do) begin
         resp_valid <= 1'b1;
         hit        <= w_lk_hit;
         hit_way    <= w_lk_hit_way;
         victim_way <= w_lk_victim;
      end else begin
         resp_valid <= 1'b0;
         hit        <= 1'b0;
         hit_way    <= '0;
         victim_way <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Flush FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= c_ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (flush_req) w_state_nxt = c_ST_SWEEP;
         // Terminal set detected explicitly; the counter never re-sweeps
         c_ST_SWEEP: if (r_cnt == c_LAST_SET) w_state_nxt = c_ST_DONE;
         c_ST_DONE:  w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      flush_busy   = (r_state == c_ST_SWEEP) || (r_state == c_ST_DONE);
      flush_done   = (r_state == c_ST_DONE);
      lookup_ready = (r_state == c_ST_IDLE);
   end

   // Set counter holds 0 outside the sweep so each sweep starts at set 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (r_state == c_ST_SWEEP)
         r_cnt <= r_cnt + INDEX_BITS'(1);
      else
         r_cnt <= '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_valid_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_tag_valid_array
//  Description : Directed, table-driven bench for cache_tag_valid_array with
//                hand-written flush and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_tag_valid_array;

   logic       clk;
   logic       reset;
   logic       lookup_valid;
   logic [4:0] lookup_addr;
   logic       lookup_ready;
   logic       resp_valid;
   logic       hit;
   logic [0:0] hit_way;
   logic [0:0] victim_way;
   logic       fill_valid;
   logic [4:0] fill_addr;
   logic       inv_valid;
   logic [4:0] inv_addr;
   logic       flush_req;
   logic       flush_busy;
   logic       flush_done;

   cache_tag_valid_array #(
      .ADDR_BITS  (5),
      .INDEX_BITS (3),
      .WAYS       (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lookup_valid (lookup_valid),
      .lookup_addr  (lookup_addr),
      .lookup_ready (lookup_ready),
      .resp_valid   (resp_valid),
      .hit          (hit),
      .hit_way      (hit_way),
      .victim_way   (victim_way),
      .fill_valid   (fill_valid),
      .fill_addr    (fill_addr),
      .inv_valid    (inv_valid),
      .inv_addr     (inv_addr),
      .flush_req    (flush_req),
      .flush_busy   (flush_busy),
      .flush_done   (flush_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       lk;
      logic [4:0] lk_a;
      logic       fl;
      logic [4:0] fl_a;
      logic       iv;
      logic [4:0] iv_a;
      logic       rv;
      logic       h;
      logic       hw;
      logic       cv;
      logic       vw;
   } vec_t;

   localparam int c_NVEC = 25;
   vec_t vecs [c_NVEC];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      lookup_valid = 1'b0; lookup_addr = '0;
      fill_valid   = 1'b0; fill_addr   = '0;
      inv_valid    = 1'b0; inv_addr    = '0;
      flush_req    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fill(input logic [4:0] a);
      idle_inputs();
      fill_valid = 1'b1; fill_addr = a;
      step();
      idle_inputs();
   endtask

   task automatic lookup_miss(input logic [4:0] a, input string nm);
      idle_inputs();
      lookup_valid = 1'b1; lookup_addr = a;
      step();
      chk({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, " hit"}, 32'(hit), 32'd0);
      idle_inputs();
   endtask

   function automatic vec_t mk(input logic lk, input logic [4:0] lk_a,
                               input logic fl, input logic [4:0] fl_a,
                               input logic iv, input logic [4:0] iv_a,
                               input logic rv, input logic h, input logic hw,
                               input logic cv, input logic vw);
      vec_t v;
      v = '{lk, lk_a, fl, fl_a, iv, iv_a, rv, h, hw, cv, vw};
      return v;
   endfunction

   int busy_cnt;
   int done_cnt;
   int done_at;
   int bad_resp;

   initial begin
      //        lk  addr   fl  addr   iv  addr   rv h  hw cv vw
      vecs[0]  = mk(1, 5'h0A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 0);
      vecs[1]  = mk(0, 5'h00, 1, 5'h0A, 0, 5'h00, 0, 0, 0, 1, 0);
      vecs[2]  = mk(1, 5'h0A, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0, 0);
      vecs[3]  = mk(1, 5'h1A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 1);
      vecs[4]  = mk(0, 5'h00, 1, 5'h02, 0, 5'h00, 0, 0, 0, 0, 0);
      vecs[5]  = mk(0, 5'h00, 1, 5'h12, 0, 5'h00, 0, 0, 0, 0, 0);
      vecs[6]  = mk(1, 5'h0A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 1);
      vecs[7]  = mk(1, 5'h12, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0, 0);
      vecs[8]  = mk(1, 5'h02, 0, 5'h00, 0, 5'h00, 1, 1, 1, 0, 0);
      vecs[9]  = mk(0, 5'h00, 1, 5'h0A, 0, 5'h00, 0, 0, 0, 0, 0);
      vecs[10] = mk(1, 5'h02, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 0);
      vecs[11] = mk(0, 5'h00, 0, 5'h00, 1, 5'h12, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 5'h12, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 0);
      vecs[13] = mk(1, 5'h0A, 1, 5'h0A, 0, 5'h00, 1, 1, 1, 0, 0);
      vecs[14] = mk(1, 5'h1A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 0);
      vecs[15] = mk(1, 5'h05, 1, 5'h05, 0, 5'h00, 1, 0, 0, 1, 0);
      vecs[16] = mk(1, 5'h05, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0, 0);
      vecs[17] = mk(0, 5'h00, 1, 5'h0A, 1, 5'h0A, 0, 0, 0, 0, 0);
      vecs[18] = mk(1, 5'h0A, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0, 0);
      vecs[19] = mk(1, 5'h0A, 0, 5'h00, 1, 5'h1A, 1, 1, 0, 0, 0);
      vecs[20] = mk(1, 5'h1A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 1);
      vecs[21] = mk(0, 5'h00, 1, 5'h1A, 0, 5'h00, 0, 0, 0, 0, 0);
      vecs[22] = mk(0, 5'h00, 1, 5'h02, 0, 5'h00, 0, 0, 0, 0, 0);
      vecs[23] = mk(1, 5'h0A, 0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 1);
      vecs[24] = mk(1, 5'h1A, 0, 5'h00, 0, 5'h00, 1, 1, 1, 0, 0);

      // ---------------- reset state ----------------
      idle_inputs();
      reset = 1'b1;
      #12;
      chk("reset resp_valid",   32'(resp_valid),   32'd0);
      chk("reset hit",          32'(hit),          32'd0);
      chk("reset flush_busy",   32'(flush_busy),   32'd0);
      chk("reset flush_done",   32'(flush_done),   32'd0);
      chk("reset lookup_ready", 32'(lookup_ready), 32'd1);
      @(posedge clk);
      #1 reset = 1'b0;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < c_NVEC; i++) begin
         lookup_valid = vecs[i].lk; lookup_addr = vecs[i].lk_a;
         fill_valid   = vecs[i].fl; fill_addr   = vecs[i].fl_a;
         inv_valid    = vecs[i].iv; inv_addr    = vecs[i].iv_a;
         flush_req    = 1'b0;
         step();
         chk($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].rv));
         chk($sformatf("vec%0d hit", i),        32'(hit),        32'(vecs[i].h));
         chk($sformatf("vec%0d hit_way", i),    32'(hit_way),    32'(vecs[i].hw));
         if (vecs[i].cv)
            chk($sformatf("vec%0d victim_way", i), 32'(victim_way), 32'(vecs[i].vw));
      end
      idle_inputs();

      // ---------------- full flush sweep ----------------
      do_reset();
      for (int a = 0; a < 16; a++) do_fill(5'(a));
      idle_inputs();
      lookup_valid = 1'b1; lookup_addr = 5'h0B;
      step();
      chk("preflush hit", 32'(hit), 32'd1);

      // flush_req together with fill and lookup: flush wins
      idle_inputs();
      flush_req = 1'b1;
      fill_valid = 1'b1; fill_addr = 5'h1F;
      lookup_valid = 1'b1; lookup_addr = 5'h1F;
      step();
      chk("flush start resp_valid",   32'(resp_valid),   32'd0);
      chk("flush start busy",         32'(flush_busy),   32'd1);
      chk("flush start lookup_ready", 32'(lookup_ready), 32'd0);
      busy_cnt = 1;
      done_cnt = 32'(flush_done);
      done_at  = flush_done ? 1 : 0;
      bad_resp = 0;
      flush_req = 1'b0;
      fill_addr = 5'h18;
      lookup_addr = 5'h00;
      for (int c = 0; c < 20; c++) begin
         step();
         if (resp_valid) bad_resp++;
         if (flush_done) begin
            done_cnt++;
            done_at = busy_cnt + 1;
         end
         if (flush_busy) busy_cnt++;
         else break;
      end
      idle_inputs();
      chk("flush busy cycles",       32'(busy_cnt), 32'd9);
      chk("flush done pulses",       32'(done_cnt), 32'd1);
      chk("flush done position",     32'(done_at),  32'd9);
      chk("lookup during flush",     32'(bad_resp), 32'd0);
      chk("post flush lookup_ready", 32'(lookup_ready), 32'd1);
      for (int a = 0; a < 16; a += 3) lookup_miss(5'(a), $sformatf("postflush 0x%0h", a));
      lookup_miss(5'h1F, "postflush 0x1f");
      lookup_miss(5'h18, "dropped fill 0x18");

      // ---------------- reset during sweep ----------------
      do_fill(5'h0A);
      do_fill(5'h03);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      repeat (3) step();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort flush_busy",   32'(flush_busy),   32'd0);
      chk("abort flush_done",   32'(flush_done),   32'd0);
      chk("abort lookup_ready", 32'(lookup_ready), 32'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (flush_done || flush_busy) done_cnt++;
      end
      chk("abort no done/busy", 32'(done_cnt), 32'd0);
      lookup_miss(5'h0A, "abort 0x0a");
      lookup_miss(5'h03, "abort 0x03");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
